// File: rtl/common_types_pkg.sv
// -----------------------------------------------------------------------------
// common_types_pkg
// Shared types for the front end of the core.
//   word_t        : 32-bit machine word (addresses and instructions)
//   fetch_state_t : fetch unit controller states
//   align_word()  : clears the two low bits of a byte address
//   next_fetch_pc(): sequential / predicted successor of a fetch address
// -----------------------------------------------------------------------------
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam word_t INST_BYTES = 32'd4;
  localparam word_t ALIGN_MASK = 32'hFFFF_FFFC;

  // Masking (rather than slicing) keeps every input bit referenced.
  function automatic word_t align_word(input word_t addr);
    return addr & ALIGN_MASK;
  endfunction

  // Sequential successor wraps modulo 2^32 through plain unsigned overflow.
  function automatic word_t next_fetch_pc(input word_t pc,
                                          input logic  predict,
                                          input word_t target);
    return predict ? align_word(target) : (pc + INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch controller. Issues one instruction-memory request at a
// time, forwards the response to the fetch/decode latch in the same cycle it
// arrives, parks it in a one-entry hold buffer while decode stalls, and
// follows execute-stage redirects (dropping any in-flight response).
//
// Ports
//   clk, nrst                 clock, synchronous active-low reset
//   imem_ren, imem_addr       read request / address to instruction memory
//   imem_ready, imem_rdata    response strobe / instruction word
//   bp_predict, bp_target     branch predictor lookup for imem_addr
//   stall                     decode latch not accepting
//   redirect, redirect_pc     execute-stage PC correction
//   fd_en, fd_flush           fetch/decode latch enable / flush
//   fd_pc, fd_inst,
//   fd_branch_predict,
//   fd_branch_target          fetch/decode latch payload
// -----------------------------------------------------------------------------
module fetch_unit
  import common_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  nrst,
  output logic  imem_ren,
  output word_t imem_addr,
  input  logic  imem_ready,
  input  word_t imem_rdata,
  input  logic  bp_predict,
  input  word_t bp_target,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  output logic  fd_en,
  output logic  fd_flush,
  output word_t fd_pc,
  output word_t fd_inst,
  output logic  fd_branch_predict,
  output word_t fd_branch_target
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        disc_addr_q, disc_addr_d;
  logic         hold_vld_q, hold_vld_d;
  // The held instruction's PC is not buffered: pc_q does not move while the
  // unit sits in HOLD, so it still names the buffered instruction.
  word_t        hold_inst_q, hold_inst_d;
  logic         hold_pred_q, hold_pred_d;
  word_t        hold_tgt_q, hold_tgt_d;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    disc_addr_d       = disc_addr_q;
    hold_vld_d        = hold_vld_q;
    hold_inst_d       = hold_inst_q;
    hold_pred_d       = hold_pred_q;
    hold_tgt_d        = hold_tgt_q;

    imem_ren          = 1'b0;
    imem_addr         = pc_q;
    fd_en             = 1'b0;
    fd_flush          = 1'b0;
    fd_pc             = pc_q;
    fd_inst           = imem_rdata;
    fd_branch_predict = bp_predict;
    fd_branch_target  = align_word(bp_target);

    case (state_q)
      ST_FETCH: begin
        imem_ren = 1'b1;
        if (redirect) begin
          fd_flush   = 1'b1;
          pc_d       = align_word(redirect_pc);
          hold_vld_d = 1'b0;
          // An unanswered request must still be drained; remember its address
          // so the request stays stable until memory responds.
          if (!imem_ready) begin
            state_d     = ST_DISCARD;
            disc_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            fd_en = 1'b1;
            pc_d  = next_fetch_pc(pc_q, bp_predict, bp_target);
          end else begin
            hold_vld_d  = 1'b1;
            hold_inst_d = imem_rdata;
            hold_pred_d = bp_predict;
            hold_tgt_d  = align_word(bp_target);
            state_d     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        fd_inst           = hold_inst_q;
        fd_branch_predict = hold_pred_q;
        fd_branch_target  = hold_tgt_q;
        if (redirect) begin
          fd_flush   = 1'b1;
          pc_d       = align_word(redirect_pc);
          hold_vld_d = 1'b0;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          fd_en      = hold_vld_q;
          pc_d       = next_fetch_pc(pc_q, hold_pred_q, hold_tgt_q);
          hold_vld_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        imem_ren  = 1'b1;
        imem_addr = disc_addr_q;
        if (redirect) begin
          fd_flush = 1'b1;
          pc_d     = align_word(redirect_pc);
        end
        // The stale response is consumed here and never reaches decode.
        if (imem_ready) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // While reset is asserted the latch is flushed and all outputs are quiet.
    if (!nrst) begin
      imem_ren          = 1'b0;
      imem_addr         = '0;
      fd_en             = 1'b0;
      fd_flush          = 1'b1;
      fd_pc             = '0;
      fd_inst           = '0;
      fd_branch_predict = 1'b0;
      fd_branch_target  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      disc_addr_q <= '0;
      hold_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      hold_vld_q  <= hold_vld_d;
    end
  end

  // Hold buffer payload is only observed while hold_vld_q is set, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    hold_inst_q <= hold_inst_d;
    hold_pred_q <= hold_pred_d;
    hold_tgt_q  <= hold_tgt_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Memory and predictor are modelled as
// pure functions of the address; the random scenario tracks the expected
// instruction stream (next PC to be delivered) at transaction level.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import common_types_pkg::*;

  logic  clk;
  logic  nrst;
  logic  imem_ren;
  word_t imem_addr;
  logic  imem_ready;
  word_t imem_rdata;
  logic  bp_predict;
  word_t bp_target;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  fd_en;
  logic  fd_flush;
  word_t fd_pc;
  word_t fd_inst;
  logic  fd_branch_predict;
  word_t fd_branch_target;

  int n_tests = 0;
  int n_fail  = 0;
  int pred_mode;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .nrst(nrst),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .bp_predict(bp_predict), .bp_target(bp_target),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .fd_en(fd_en), .fd_flush(fd_flush),
    .fd_pc(fd_pc), .fd_inst(fd_inst),
    .fd_branch_predict(fd_branch_predict), .fd_branch_target(fd_branch_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic word_t mem_word(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic pred_of(input word_t a, input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return (a == 32'h10);
    return (a[4:2] == 3'b011);
  endfunction

  // Raw predictor target deliberately carries nonzero low bits.
  function automatic word_t tgt_of(input word_t a, input int mode);
    if (mode == 1) return 32'h40;
    return ((a ^ 32'h0000_05A4) & 32'h0000_0FFC) | 32'h1;
  endfunction

  // Memory and predictor respond combinationally to the current address.
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  assign bp_predict = pred_of(imem_addr, pred_mode);
  assign bp_target  = tgt_of(imem_addr, pred_mode);

  task automatic do_reset();
    nrst = 1'b0; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    pred_mode = 0;
    nrst = 1'b0; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk); #1;
    n_tests++; if (imem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %0b want 0", imem_ren); end
    n_tests++; if (fd_en !== 1'b0) begin n_fail++; $display("FAIL reset_fd_en: got %0b want 0", fd_en); end
    n_tests++; if (fd_flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush: got %0b want 1", fd_flush); end
    n_tests++; if ({fd_pc, fd_inst, fd_branch_target, fd_branch_predict} !== 97'd0) begin
      n_fail++; $display("FAIL reset_payload: got pc=%h inst=%h tgt=%h pred=%0b want all 0", fd_pc, fd_inst, fd_branch_target, fd_branch_predict); end
    @(negedge clk);
    nrst = 1'b1; imem_ready = 1'b0;
    #1;
    n_tests++; if (imem_ren !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_req: got ren=%0b addr=%h want 1/00000000", imem_ren, imem_addr); end
    n_tests++; if (fd_flush !== 1'b0 || fd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ctl: got flush=%0b en=%0b want 0/0", fd_flush, fd_en); end
  endtask

  task automatic test_sequential();
    pred_mode = 0;
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (imem_addr !== word_t'(4 * i) || fd_en !== 1'b1 || fd_pc !== word_t'(4 * i)
                     || fd_inst !== mem_word(word_t'(4 * i))) begin
        n_fail++; $display("FAIL seq_%0d: got addr=%h en=%0b pc=%h inst=%h want addr=pc=%h en=1", i, imem_addr, fd_en, fd_pc, fd_inst, 4 * i); end
      @(negedge clk);
    end
  endtask

  task automatic test_predict();
    pred_mode = 1;
    do_reset();
    imem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_tests++; if (imem_addr !== 32'h10 || fd_en !== 1'b1 || fd_branch_predict !== 1'b1 || fd_branch_target !== 32'h40) begin
      n_fail++; $display("FAIL predict_payload: got addr=%h en=%0b pred=%0b tgt=%h want 10/1/1/40", imem_addr, fd_en, fd_branch_predict, fd_branch_target); end
    @(negedge clk); #1;
    n_tests++; if (imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL predict_next: got addr=%h want 00000040", imem_addr); end
    pred_mode = 0;
  endtask

  task automatic test_stall_hold();
    int pulses;
    pred_mode = 0;
    do_reset();
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    stall = 1'b1;
    #1;
    pulses = int'(fd_en);
    n_tests++; if (imem_addr !== 32'h8 || imem_ren !== 1'b1 || fd_en !== 1'b0) begin
      n_fail++; $display("FAIL stall_capture: got addr=%h ren=%0b en=%0b want 8/1/0", imem_addr, imem_ren, fd_en); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); imem_ready = 1'b0; #1;
      pulses += int'(fd_en);
      n_tests++; if (imem_ren !== 1'b0 || fd_pc !== 32'h8 || fd_inst !== mem_word(32'h8)) begin
        n_fail++; $display("FAIL stall_hold_%0d: got ren=%0b pc=%h inst=%h want 0/8/%h", i, imem_ren, fd_pc, fd_inst, mem_word(32'h8)); end
    end
    @(negedge clk); stall = 1'b0; #1;
    pulses += int'(fd_en);
    n_tests++; if (fd_en !== 1'b1 || fd_pc !== 32'h8 || fd_inst !== mem_word(32'h8)) begin
      n_fail++; $display("FAIL stall_release: got en=%0b pc=%h inst=%h want 1/8/%h", fd_en, fd_pc, fd_inst, mem_word(32'h8)); end
    @(negedge clk); imem_ready = 1'b1; #1;
    pulses += int'(fd_en);
    n_tests++; if (imem_addr !== 32'hC || imem_ren !== 1'b1) begin
      n_fail++; $display("FAIL stall_next: got addr=%h ren=%0b want C/1", imem_addr, imem_ren); end
    n_tests++; if (pulses !== 2) begin
      n_fail++; $display("FAIL stall_pulses: got %0d fd_en pulses want 2 (release + next)", pulses); end
  endtask

  task automatic test_redirect_outstanding();
    pred_mode = 0;
    do_reset();
    imem_ready = 1'b1;
    repeat (8) @(negedge clk);
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    n_tests++; if (fd_flush !== 1'b1 || fd_en !== 1'b0 || imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL redir_flush: got flush=%0b en=%0b addr=%h want 1/0/20", fd_flush, fd_en, imem_addr); end
    @(negedge clk); redirect = 1'b0; #1;
    n_tests++; if (fd_flush !== 1'b0 || imem_ren !== 1'b1 || imem_addr !== 32'h20 || fd_en !== 1'b0) begin
      n_fail++; $display("FAIL redir_discard: got flush=%0b ren=%0b addr=%h en=%0b want 0/1/20/0", fd_flush, imem_ren, imem_addr, fd_en); end
    @(negedge clk); imem_ready = 1'b1; #1;
    n_tests++; if (fd_en !== 1'b0) begin
      n_fail++; $display("FAIL redir_drop: got en=%0b want 0", fd_en); end
    @(negedge clk); #1;
    n_tests++; if (imem_addr !== 32'h100 || fd_en !== 1'b1 || fd_pc !== 32'h100 || fd_inst !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL redir_next: got addr=%h en=%0b pc=%h want 100/1/100", imem_addr, fd_en, fd_pc); end
  endtask

  task automatic test_redirect_ready_wrap();
    pred_mode = 0;
    do_reset();
    imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    #1;
    n_tests++; if (fd_flush !== 1'b1 || fd_en !== 1'b0) begin
      n_fail++; $display("FAIL coinc_flush: got flush=%0b en=%0b want 1/0", fd_flush, fd_en); end
    @(negedge clk); redirect = 1'b0; #1;
    n_tests++; if (imem_addr !== 32'hFFFF_FFFC || fd_en !== 1'b1 || fd_pc !== 32'hFFFF_FFFC || fd_inst !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL coinc_next: got addr=%h en=%0b pc=%h want FFFFFFFC/1/FFFFFFFC", imem_addr, fd_en, fd_pc); end
    @(negedge clk); #1;
    n_tests++; if (imem_addr !== 32'h0 || fd_pc !== 32'h0 || fd_en !== 1'b1) begin
      n_fail++; $display("FAIL wrap: got addr=%h pc=%h en=%0b want 0/0/1", imem_addr, fd_pc, fd_en); end
  endtask

  task automatic test_reset_mid_hold();
    pred_mode = 0;
    do_reset();
    imem_ready = 1'b1; stall = 1'b1;
    @(negedge clk); imem_ready = 1'b0; #1;
    n_tests++; if (imem_ren !== 1'b0) begin
      n_fail++; $display("FAIL midhold_in_hold: got ren=%0b want 0", imem_ren); end
    @(negedge clk); nrst = 1'b0; #1;
    n_tests++; if (imem_ren !== 1'b0 || fd_en !== 1'b0 || fd_flush !== 1'b1 ||
                   {fd_pc, fd_inst, fd_branch_target, fd_branch_predict} !== 97'd0) begin
      n_fail++; $display("FAIL midhold_reset_out: got ren=%0b en=%0b flush=%0b pc=%h inst=%h want 0/0/1 payload 0", imem_ren, fd_en, fd_flush, fd_pc, fd_inst); end
    @(negedge clk); nrst = 1'b1; stall = 1'b0; #1;
    n_tests++; if (imem_ren !== 1'b1 || imem_addr !== 32'h0 || fd_en !== 1'b0) begin
      n_fail++; $display("FAIL midhold_first_req: got ren=%0b addr=%h en=%0b want 1/0/0", imem_ren, imem_addr, fd_en); end
    @(negedge clk); imem_ready = 1'b1; #1;
    n_tests++; if (fd_en !== 1'b1 || fd_pc !== 32'h0) begin
      n_fail++; $display("FAIL midhold_accept: got en=%0b pc=%h want 1/0", fd_en, fd_pc); end
  endtask

  // Random traffic against a stream model: each delivered instruction must be
  // the next one in program order, where order follows predictions and is
  // restarted by every redirect.
  task automatic test_random();
    word_t exp_pc, prev_addr, exp_next;
    logic  prev_wait;
    int    accepted;
    pred_mode = 2;
    do_reset();
    exp_pc = 32'h0; prev_wait = 1'b0; prev_addr = '0; accepted = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i != 0) @(negedge clk);
      imem_ready  = ($urandom_range(0, 9) < 6);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | word_t'($urandom_range(0, 15)))
                                                : word_t'($urandom_range(0, 4095));
      #1;
      if (prev_wait) begin
        n_tests++; if (imem_ren !== 1'b1 || imem_addr !== prev_addr) begin
          n_fail++; $display("FAIL rnd_req_stable @%0d: got ren=%0b addr=%h want 1/%h", i, imem_ren, imem_addr, prev_addr); end
      end
      if (redirect) begin
        n_tests++; if (fd_flush !== 1'b1 || fd_en !== 1'b0) begin
          n_fail++; $display("FAIL rnd_redirect @%0d: got flush=%0b en=%0b want 1/0", i, fd_flush, fd_en); end
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        n_tests++; if (fd_flush !== 1'b0) begin
          n_fail++; $display("FAIL rnd_noflush @%0d: got flush=%0b want 0", i, fd_flush); end
        if (fd_en === 1'b1) begin
          n_tests++; if (stall !== 1'b0) begin
            n_fail++; $display("FAIL rnd_en_in_stall @%0d: got en=1 with stall=1 want en=0", i); end
          n_tests++; if (fd_pc !== exp_pc || fd_inst !== mem_word(exp_pc) ||
                         fd_branch_predict !== pred_of(exp_pc, 2) ||
                         fd_branch_target !== (tgt_of(exp_pc, 2) & 32'hFFFF_FFFC)) begin
            n_fail++; $display("FAIL rnd_payload @%0d: got pc=%h inst=%h pred=%0b tgt=%h want pc=%h inst=%h", i, fd_pc, fd_inst, fd_branch_predict, fd_branch_target, exp_pc, mem_word(exp_pc)); end
          exp_next = pred_of(exp_pc, 2) ? (tgt_of(exp_pc, 2) & 32'hFFFF_FFFC) : exp_pc + 32'd4;
          exp_pc = exp_next;
          accepted++;
        end
      end
      prev_wait = imem_ren && !imem_ready;
      prev_addr = imem_addr;
    end
    n_tests++; if (accepted < 300) begin
      n_fail++; $display("FAIL rnd_progress: got %0d accepted want at least 300", accepted); end
    @(negedge clk);
    imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    pred_mode = 0;
    test_reset();
    test_sequential();
    test_predict();
    test_stall_hold();
    test_redirect_outstanding();
    test_redirect_ready_wrap();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
